crc8_framer: RTL and testbench
==============================

CRC8_FRAMER -- requirements
Module: crc8_framer

Interface
REQ-001 Parameter POLYNOMIAL, default 8'h07: CRC-8 generator polynomial, passed unchanged to the engine.
REQ-002 Parameter INITIAL, default 8'h00: CRC seed loaded into the engine at every frame start.
REQ-003 Parameter CNT_W, default 16: width of the frame counter.
REQ-004 clk_i  input  1  clock; all logic on its rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 s_data_i  input  8  payload byte in.
REQ-007 s_valid_i  input  1  payload byte valid.
REQ-008 s_last_i  input  1  marks the final payload byte of a frame.
REQ-009 s_ready_o  output  1  framer accepts the byte this cycle.
REQ-010 abort_i  input  1  discard the current frame; no CRC is emitted.
REQ-011 m_data_o  output  8  output byte: payload or CRC.
REQ-012 m_valid_o  output  1  output byte valid.
REQ-013 m_last_o  output  1  marks the CRC byte, which is always the final byte of an output frame.
REQ-014 m_ready_i  input  1  downstream accepts the byte.
REQ-015 frame_cnt_o  output  CNT_W  count of completed (CRC-emitted) frames.
REQ-016 busy_o  output  1  a frame is in progress (state DATA with at least one byte accepted, or state EMIT).

Function
REQ-017 The FSM SHALL have exactly three states: CLR, DATA, EMIT.
REQ-018 CLR: engine reset asserted for exactly one cycle; s_ready_o=0, m_valid_o=0; next state is always DATA.
REQ-019 DATA: pass-through; m_data_o=s_data_i, m_valid_o=s_valid_i, s_ready_o=m_ready_i, m_last_o=0.
REQ-020 A byte is accepted when s_valid_i and s_ready_o are both high, and the engine data_valid_i is driven high in that same cycle.
REQ-021 Back-to-back accepted bytes SHALL be processed one per cycle with no bubbles.
REQ-022 Acceptance with s_last_i=1 SHALL move the FSM to EMIT on the next edge.
REQ-023 EMIT: m_data_o=engine crc_o, m_valid_o=1, m_last_o=1, s_ready_o=0.
REQ-024 The CRC byte SHALL be valid in the first EMIT cycle, one cycle after the last accept.
REQ-025 The CRC byte SHALL be held stable under m_ready_i=0 for any number of cycles.
REQ-026 The EMIT handshake (m_valid_o and m_ready_i both high) SHALL increment frame_cnt_o and move the FSM to CLR; the counter wraps from all-ones to 0.
REQ-027 abort_i high in DATA SHALL move the FSM to CLR and suppress the current byte (s_ready_o=0, m_valid_o=0 that cycle).
REQ-028 abort_i high in EMIT SHALL move the FSM to CLR, suppress the CRC byte and leave frame_cnt_o unchanged.
REQ-029 abort_i in CLR SHALL be ignored.
REQ-030 abort_i SHALL take priority over a simultaneous accept or EMIT handshake.
REQ-031 The engine reset SHALL be the OR of rst_i and a registered CLR-state flag, so it carries no combinational glitch.
REQ-032 A frame consisting of one byte with s_last_i=1 is legal and SHALL yield 2 output bytes.

Reset
REQ-033 rst_i asserted SHALL force: state=CLR, frame_cnt_o=0, s_ready_o=0, m_valid_o=0, m_last_o=0, busy_o=0, engine CRC=INITIAL.
REQ-034 rst_i mid-frame or mid-EMIT SHALL drop the frame silently; after release, the first edge is CLR and the next frame starts clean.

Structure
REQ-035 Package crc8_pkg SHALL hold the state encoding (CLR/DATA/EMIT) and the default POLYNOMIAL, INITIAL and CNT_W constants.
REQ-036 The framer SHALL instantiate exactly one crc8 sub-module as its CRC engine and no other CRC logic.

Verification
REQ-037 Test 1: bytes "123456789" (0x31..0x39), last on 0x39, m_ready_i=1 -> 10 output bytes, final byte 0xF4 with m_last_o=1; frame_cnt_o=1.
REQ-038 Test 2: single byte 0x01 with last -> output 0x01 then 0x07; single byte 0x00 -> output 0x00 then 0x00.
REQ-039 Test 3: "123456789", then m_ready_i=0 for 5 cycles in EMIT -> m_data_o holds 0xF4 throughout; counter increments only on the handshake.
REQ-040 Test 4: abort_i after 4 bytes, then "123456789" -> first frame emits no CRC byte; second frame CRC is 0xF4 (proves the engine was cleared); frame_cnt_o=1.
REQ-041 Test 5: rst_i pulse mid-frame after byte 3 -> all outputs 0 during reset; next frame "123456789" yields 0xF4.
REQ-042 Test 6: preload so frame_cnt_o=16'hFFFF, complete one frame -> frame_cnt_o=0.

Source files
------------

// File: rtl/crc8_pkg.sv
//------------------------------------------------------------------------------
// crc8_pkg : shared state encoding, default parameters and CRC-8 step function
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package crc8_pkg;

  typedef enum logic [1:0] {
    ST_CLR  = 2'd0,
    ST_DATA = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  localparam logic [7:0] DEF_POLYNOMIAL = 8'h07;
  localparam logic [7:0] DEF_INITIAL    = 8'h00;
  localparam int         DEF_CNT_W      = 16;

  // MSB-first, non-reflected CRC-8 update over one byte
  function automatic logic [7:0] crc8_next(input logic [7:0] crc,
                                           input logic [7:0] data,
                                           input logic [7:0] poly);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ poly) : (c << 1);
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/crc8.sv
//------------------------------------------------------------------------------
// crc8 : byte-wide CRC-8 engine, one byte per cycle, seeded by reset
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module crc8
  import crc8_pkg::*;
#(
  parameter logic [7:0] POLYNOMIAL = DEF_POLYNOMIAL,
  parameter logic [7:0] INITIAL    = DEF_INITIAL
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       data_valid_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (data_valid_i) begin
      crc_d = crc8_next(crc_q, data_i, POLYNOMIAL);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc_q <= INITIAL;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

`default_nettype wire

// File: rtl/crc8_framer.sv
//------------------------------------------------------------------------------
// crc8_framer : passes payload bytes through and appends a CRC-8 byte per frame
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module crc8_framer
  import crc8_pkg::*;
#(
  parameter logic [7:0] POLYNOMIAL = DEF_POLYNOMIAL,
  parameter logic [7:0] INITIAL    = DEF_INITIAL,
  parameter int         CNT_W      = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [7:0]       s_data_i,
  input  logic             s_valid_i,
  input  logic             s_last_i,
  output logic             s_ready_o,
  input  logic             abort_i,
  output logic [7:0]       m_data_o,
  output logic             m_valid_o,
  output logic             m_last_o,
  input  logic             m_ready_i,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic             busy_o
);

  state_e           state_q, state_d;
  logic             clr_q;
  logic             started_q, started_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             eng_rst;
  logic [7:0]       eng_crc;

  // clr_q mirrors "state is CLR" from a flop so the engine reset is glitch-free
  assign eng_rst = rst_i | clr_q;

  crc8 #(
    .POLYNOMIAL (POLYNOMIAL),
    .INITIAL    (INITIAL)
  ) u_crc8 (
    .clk_i        (clk_i),
    .rst_i        (eng_rst),
    .data_i       (s_data_i),
    .data_valid_i (accept),
    .crc_o        (eng_crc)
  );

  always_comb begin
    state_d   = state_q;
    started_d = started_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    s_ready_o = 1'b0;
    m_valid_o = 1'b0;
    m_last_o  = 1'b0;
    m_data_o  = s_data_i;
    unique case (state_q)
      ST_CLR: begin
        state_d   = ST_DATA;
        started_d = 1'b0;
      end
      ST_DATA: begin
        if (abort_i) begin
          state_d   = ST_CLR;
          started_d = 1'b0;
        end else begin
          s_ready_o = m_ready_i;
          m_valid_o = s_valid_i;
          accept    = s_valid_i & m_ready_i;
          if (accept) begin
            started_d = 1'b1;
            if (s_last_i) begin
              state_d = ST_EMIT;
            end
          end
        end
      end
      ST_EMIT: begin
        m_data_o = eng_crc;
        if (abort_i) begin
          state_d = ST_CLR;
        end else begin
          m_valid_o = 1'b1;
          m_last_o  = 1'b1;
          if (m_ready_i) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ST_CLR;
          end
        end
      end
      default: begin
        state_d = ST_CLR;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_CLR;
      clr_q     <= 1'b1;
      started_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_q     <= (state_d == ST_CLR);
      started_q <= started_d;
      cnt_q     <= cnt_d;
    end
  end

  assign frame_cnt_o = cnt_q;
  assign busy_o      = ((state_q == ST_DATA) && started_q) || (state_q == ST_EMIT);

endmodule

`default_nettype wire

// File: tb/tb_crc8_framer.sv
//------------------------------------------------------------------------------
// tb_crc8_framer : directed frames, scoreboard queue checked by a monitor
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_crc8_framer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  s_data_i = '0;
  logic        s_valid_i = 1'b0;
  logic        s_last_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        m_ready_i = 1'b1;
  logic        s_ready_o, m_valid_o, m_last_o, busy_o;
  logic [7:0]  m_data_o;
  logic [15:0] frame_cnt_o;
  logic        s_ready2, m_valid2, m_last2, busy2;
  logic [7:0]  m_data2;
  logic [1:0]  frame_cnt2;

  always #5 clk_i = ~clk_i;

  crc8_framer dut (
    .clk_i(clk_i), .rst_i(rst_i), .s_data_i(s_data_i), .s_valid_i(s_valid_i),
    .s_last_i(s_last_i), .s_ready_o(s_ready_o), .abort_i(abort_i),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_last_o(m_last_o),
    .m_ready_i(m_ready_i), .frame_cnt_o(frame_cnt_o), .busy_o(busy_o)
  );

  // narrow counter copy exercises the all-ones to zero wrap in a few frames
  crc8_framer #(.CNT_W(2)) dut_w2 (
    .clk_i(clk_i), .rst_i(rst_i), .s_data_i(s_data_i), .s_valid_i(s_valid_i),
    .s_last_i(s_last_i), .s_ready_o(s_ready2), .abort_i(abort_i),
    .m_data_o(m_data2), .m_valid_o(m_valid2), .m_last_o(m_last2),
    .m_ready_i(m_ready_i), .frame_cnt_o(frame_cnt2), .busy_o(busy2)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  int         n_pop = 0;
  int         exp_cnt = 0;
  bit         cnt_pend = 1'b0;
  logic [8:0] exp_q [$];
  logic [7:0] frm [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on every output handshake
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        exp_cnt  = 0;
        cnt_pend = 1'b0;
      end else begin
        if (cnt_pend) begin
          chk("frame_cnt", 32'(frame_cnt_o), 32'(exp_cnt));
          chk("frame_cnt_w2", 32'(frame_cnt2), 32'(exp_cnt % 4));
          cnt_pend = 1'b0;
        end
        if (m_valid_o && m_ready_i) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_byte: got 0x%0h last=%0b, want none", m_data_o, m_last_o);
          end else begin
            e = exp_q.pop_front();
            n_pop++;
            chk("out_data", 32'(m_data_o), 32'(e[7:0]));
            chk("out_last", 32'(m_last_o), 32'(e[8]));
            if (m_last_o) begin
              exp_cnt++;
              cnt_pend = 1'b1;
            end
          end
        end
      end
    end
  end

  // entered and left at posedge+1; pushes expectations before the handshake
  task automatic send_byte(input logic [7:0] d, input logic l,
                           input logic [7:0] crc, input bit emit_crc);
    int t;
    s_data_i  = d;
    s_last_i  = l;
    s_valid_i = 1'b1;
    exp_q.push_back({1'b0, d});
    if (l && emit_crc) exp_q.push_back({1'b1, crc});
    t = 0;
    @(negedge clk_i);
    while (!s_ready_o && t < 50) begin
      t++;
      @(negedge clk_i);
    end
    if (!s_ready_o) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got s_ready_o=0, want 1");
    end
    @(posedge clk_i);
    #1;
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [7:0] crc, input bit emit_crc);
    for (int i = 0; i < n; i++) begin
      send_byte(frm[i], (i == n - 1), crc, emit_crc);
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      t++;
      @(negedge clk_i);
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic load_check();
    for (int i = 0; i < 9; i++) frm[i] = 8'h31 + 8'(i);
  endtask

  initial begin
    int p0;
    int c0;
    repeat (3) @(negedge clk_i);
    chk("rst_s_ready", 32'(s_ready_o), 0);
    chk("rst_m_valid", 32'(m_valid_o), 0);
    chk("rst_m_last", 32'(m_last_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_cnt", 32'(frame_cnt_o), 0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Test 1: check string
    load_check();
    p0 = n_pop;
    send_frame(9, 8'hF4, 1'b1);
    wait_done();
    chk("t1_bytes", 32'(n_pop - p0), 10);
    chk("t1_cnt", 32'(frame_cnt_o), 1);

    // Test 2: single-byte frames
    frm[0] = 8'h01;
    send_frame(1, 8'h07, 1'b1);
    wait_done();
    frm[0] = 8'h00;
    p0 = n_pop;
    send_frame(1, 8'h00, 1'b1);
    wait_done();
    chk("t2_bytes", 32'(n_pop - p0), 2);

    // Test 3: CRC held under backpressure
    load_check();
    send_frame(9, 8'hF4, 1'b1);
    m_ready_i = 1'b0;
    c0 = 32'(frame_cnt_o);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("t3_hold_data", 32'(m_data_o), 32'hF4);
      chk("t3_hold_valid", 32'(m_valid_o & m_last_o), 1);
      chk("t3_hold_cnt", 32'(frame_cnt_o), 32'(c0));
    end
    chk("t3_busy", 32'(busy_o), 1);
    @(posedge clk_i);
    #1;
    m_ready_i = 1'b1;
    wait_done();
    chk("t3_cnt", 32'(frame_cnt_o), 4);
    chk("wrap_cnt", 32'(frame_cnt2), 0);

    // idle DATA with nothing accepted is not busy
    @(negedge clk_i);
    @(negedge clk_i);
    chk("idle_busy", 32'(busy_o), 0);
    @(posedge clk_i);
    #1;

    // Test 4: abort in DATA after 4 bytes
    load_check();
    for (int i = 0; i < 4; i++) send_byte(frm[i], 1'b0, 8'h00, 1'b0);
    s_data_i  = 8'h35;
    s_valid_i = 1'b1;
    abort_i   = 1'b1;
    @(negedge clk_i);
    chk("t4_abort_ready", 32'(s_ready_o), 0);
    chk("t4_abort_valid", 32'(m_valid_o), 0);
    @(posedge clk_i);
    #1;
    abort_i   = 1'b0;
    s_valid_i = 1'b0;
    c0 = 32'(frame_cnt_o);
    send_frame(9, 8'hF4, 1'b1);
    wait_done();
    chk("t4_cnt", 32'(frame_cnt_o), 32'(c0 + 1));

    // abort in EMIT suppresses the CRC and leaves the counter alone
    frm[0] = 8'h01;
    c0 = 32'(frame_cnt_o);
    send_frame(1, 8'h07, 1'b0);
    abort_i = 1'b1;
    @(negedge clk_i);
    chk("emit_abort_valid", 32'(m_valid_o), 0);
    @(posedge clk_i);
    #1;
    abort_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("emit_abort_cnt", 32'(frame_cnt_o), 32'(c0));
    @(posedge clk_i);
    #1;

    // Test 5: reset mid-frame
    load_check();
    for (int i = 0; i < 3; i++) send_byte(frm[i], 1'b0, 8'h00, 1'b0);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("t5_rst_ready", 32'(s_ready_o), 0);
    chk("t5_rst_valid", 32'(m_valid_o), 0);
    chk("t5_rst_last", 32'(m_last_o), 0);
    chk("t5_rst_busy", 32'(busy_o), 0);
    chk("t5_rst_cnt", 32'(frame_cnt_o), 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    send_frame(9, 8'hF4, 1'b1);
    wait_done();
    chk("t5_cnt", 32'(frame_cnt_o), 1);

    repeat (2) @(negedge clk_i);
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
